// File: rtl/regbank_dump.sv
// regbank_dump: walks a register bank after a halt edge or start pulse and streams each register out over valid/ready
module regbank_dump #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          start,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] CAPT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic          halted_q;
  logic          trig;
  assign trig       = (halted & ~halted_q) | start;
  assign rf_rd_en   = state == READ;
  assign rf_rd_addr = idx;
  assign out_valid  = state == SEND;
  assign out_last   = out_valid & (out_idx == LAST);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  // dump sequencer: one read, one capture, one send slot per register; triggers only honoured in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      halted_q <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      halted_q <= halted;
      case (state)
        IDLE: if (trig) begin
          idx   <= '0;
          state <= READ;
        end
        READ: state <= CAPT;
        CAPT: begin
          out_data <= rf_rd_data;
          out_idx  <= idx;
          state    <= SEND;
        end
        SEND: if (out_ready) begin
          if (idx == LAST) state <= DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_dump.sv
// tb_regbank_dump: scoreboard bench for regbank_dump with directed dump scenarios
module tb_regbank_dump;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        halted = 0;
  logic        start = 0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  typedef struct {logic [4:0] idx; logic [31:0] data; logic last;} word_t;
  word_t sq[$];
  int    dq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    rd_cnt = 0;
  logic [31:0] bank [32];

  regbank_dump #(.NREGS(32), .DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .start(start),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rf_rd_en) rf_rd_data <= bank[rf_rd_addr];

  function automatic logic [31:0] reg_val(input int k);
    case (k)
      0: return 32'd0;
      1: return 32'd10;
      2: return 32'd20;
      3: return 32'd25;
      4: return 32'd30;
      5: return 32'd55;
      default: return 32'(k);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_dump(input int extra);
    for (int k = 0; k < 32; k++) sq.push_back('{idx: 5'(k), data: reg_val(k), last: k == 31});
    dq.push_back(cyc + 97 + extra);
  endtask

  task automatic wait_word(input int k);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #1;
      hit = out_valid && out_idx == 5'(k);
    end
    chk($sformatf("reach_word_%0d", k), 64'(hit), 64'd1);
  endtask

  task automatic wait_done();
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #1;
      hit = done;
    end
    chk("reach_done", 64'(hit), 64'd1);
  endtask

  task automatic chk_quiet(input string name, input int n);
    bit act = 0;
    repeat (n) begin
      @(posedge clk); #1;
      act |= busy | out_valid | rf_rd_en | done;
    end
    chk(name, 64'(act), 64'd0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {out_valid, rf_rd_en, busy, done, out_last, rf_rd_addr, out_idx, out_data}, 64'd0);
  endtask

  // scoreboard monitor: compares every presented word with the queue head, pops on handshake
  always @(negedge clk) begin
    if (!rst_n) rd_cnt = 0;
    else begin
      if (out_valid) begin
        if (sq.size() == 0) chk("unexpected_word", 64'(out_idx), 64'h1ff);
        else begin
          chk("out_idx", 64'(out_idx), 64'(sq[0].idx));
          chk("out_data", 64'(out_data), 64'(sq[0].data));
          chk("out_last", 64'(out_last), 64'(sq[0].last));
          if (out_ready) void'(sq.pop_front());
        end
      end else chk("last_without_valid", 64'(out_last), 64'd0);
      if (rf_rd_en) begin
        rd_cnt++;
        chk("rd_en_with_valid", 64'(out_valid), 64'd0);
        if (sq.size() == 0) chk("unexpected_read", 64'(rf_rd_addr), 64'h1ff);
        else chk("rf_rd_addr", 64'(rf_rd_addr), 64'(sq[0].idx));
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 64'(cyc), 64'hffff);
        else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
        chk("reads_per_dump", 64'(rd_cnt), 64'd32);
        rd_cnt = 0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) bank[k] = reg_val(k);
    #2;
    chk_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk_quiet("idle_after_reset", 5);

    // halted edge, full-speed dump
    halted = 1;
    push_dump(0);
    wait_done();
    chk_quiet("halted_high_no_redump", 10);
    halted = 0;
    chk_quiet("halted_fall_idle", 3);

    // start pulse with a 5-cycle backpressure stall on word 4
    start = 1;
    push_dump(5);
    @(posedge clk); #1 start = 0;
    wait_word(4);
    out_ready = 0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    wait_done();
    chk_quiet("idle_after_stall", 5);

    // start, then halted edge and start again mid-dump: ignored, halted falling does not abort
    start = 1;
    push_dump(0);
    @(posedge clk); #1 start = 0;
    wait_word(7);
    halted = 1;
    start = 1;
    @(posedge clk); #1 start = 0;
    wait_word(12);
    halted = 0;
    wait_done();
    chk_quiet("no_queued_restart", 20);

    // asynchronous reset in the middle of word 10
    start = 1;
    push_dump(0);
    @(posedge clk); #1 start = 0;
    wait_word(10);
    #1 rst_n = 0;
    #1 chk_zero("async_reset_mid_dump");
    sq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_quiet("idle_after_abort", 10);

    // halted high across reset release starts a dump; stays high afterwards
    rst_n = 0;
    halted = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    push_dump(0);
    wait_done();
    chk_quiet("no_second_dump", 20);

    chk("scoreboard_empty", 64'(sq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regbank_dump.md
REGBANK_DUMP -- requirements
Module: regbank_dump

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers dumped (indices 0..NREGS-1).
REQ-002 SHALL have parameter DW, default 32, register data width.
REQ-003 SHALL have parameter AW, default 5, register address width; NREGS <= 2**AW.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port halted, input, 1, processor HALTED flag; a rising edge triggers a dump.
REQ-007 SHALL have port start, input, 1, single-cycle manual dump trigger.
REQ-008 SHALL have port rf_rd_en, output, 1, register-bank read strobe.
REQ-009 SHALL have port rf_rd_addr, output, AW, register-bank read address.
REQ-010 SHALL have port rf_rd_data, input, DW, read data, valid exactly one cycle after rf_rd_en.
REQ-011 SHALL have port out_valid, output, 1, dump word available.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-013 SHALL have port out_idx, output, AW, register index of the current word.
REQ-014 SHALL have port out_data, output, DW, register value of the current word.
REQ-015 SHALL have port out_last, output, 1, current word is index NREGS-1.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse after the final handshake.

Function
REQ-018 SHALL implement FSM states IDLE, READ, CAPT, SEND, DONE.
REQ-019 SHALL register halted into halted_q each cycle; trigger = (halted & ~halted_q) | start, evaluated only in IDLE.
REQ-020 IDLE: on trigger, idx<=0, next state READ; otherwise stay.
REQ-021 READ: rf_rd_en=1, rf_rd_addr=idx for exactly one cycle; next state CAPT.
REQ-022 CAPT: out_data<=rf_rd_data, out_idx<=idx; next state SEND.
REQ-023 SEND: out_valid=1; out_idx, out_data, out_last SHALL stay stable until out_valid & out_ready.
REQ-024 On handshake with idx==NREGS-1: next state DONE; otherwise idx<=idx+1, next state READ.
REQ-025 DONE: done=1 for one cycle; next state IDLE.
REQ-026 Latency: trigger sampled in cycle t -> rf_rd_en in t+1 -> out_valid in t+3; with out_ready held high, one word per 3 cycles; full dump = 3*NREGS+1 cycles from trigger to done.
REQ-027 rf_rd_en SHALL be 0 outside READ; rf_rd_addr SHALL equal idx at all times.
REQ-028 out_valid SHALL be 0 outside SEND; out_last = out_valid & (out_idx==NREGS-1).
REQ-029 Triggers (halted edge or start) while busy SHALL be ignored and not queued.
REQ-030 halted falling mid-dump SHALL NOT abort; dump completes.
REQ-031 out_ready high outside SEND SHALL have no effect.
REQ-032 idx SHALL never exceed NREGS-1; no wrap-around to 0 within a dump.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, idx=0, halted_q=0, out_data=0, out_idx=0, out_valid=0, rf_rd_en=0, rf_rd_addr=0, busy=0, done=0, out_last=0.
REQ-034 Reset mid-dump SHALL abandon the dump; no partial words after release.
REQ-035 halted already high at reset release SHALL count as a rising edge (halted_q resets 0) and start a dump.

Verification
REQ-036 Bank R0=0,R1=10,R2=20,R3=25,R4=30,R5=55,Rk=k otherwise; halted 0->1, out_ready=1 -> 32 words idx 0..31 with those values, out_last only on idx 31, done 97 cycles after trigger.
REQ-037 out_ready low for 5 cycles during SEND of idx 4 -> out_valid held, out_idx=4, out_data=30 stable; no rf_rd_en until handshake.
REQ-038 start pulse, then halted rise and a second start at word idx 7 -> exactly one dump of 32 words, no restart.
REQ-039 rst_n asserted while in SEND at idx 10 -> all outputs 0 asynchronously; after release with halted=0, start=0, module stays IDLE.
REQ-040 halted high during reset then release -> dump begins; halted stays high after done -> no second dump.
REQ-041 Every READ cycle: rf_rd_addr equals idx of the following SEND word; rf_rd_en asserted exactly 32 times per dump.
